sic_mem_responder: RTL and testbench

SIC_MEM_RESPONDER -- requirements
Module: sic_mem_responder

---
 rtl/sic_mem_responder.sv | 152 +++++++++++++++
 tb/tb_sic_mem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sic_mem_responder.sv
// Word-access responder for a byte-addressed SIC memory: each 24-bit word is
// moved one byte per cycle, big-endian, with a fixed three-cycle latency.
module sic_mem_responder #(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_byte_en;
    logic [1:0]               w_lane;
    logic [1:0]               w_offset;
    logic [4:0]               w_lane_sel;
    logic [ADDRESS_WIDTH-1:0] w_byte_addr;
    logic [7:0]               w_wr_byte;
    logic [7:0]               w_rd_byte;
    logic [7:0]               w_byte;

    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic                     r_write;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_req_ready;
    logic                     r_rsp_valid;
    logic                     r_busy;
    logic [7:0]               r_mem [0:(2**ADDRESS_WIDTH)-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state byte lane selection (lane 2 = bits [23:16])
    always_comb begin
        w_state_nxt = r_state;
        w_byte_en   = 1'b0;
        w_lane      = 2'd2;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = ST_B0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_B0: begin
                w_byte_en   = 1'b1;
                w_lane      = 2'd2;
                w_state_nxt = ST_B1;
            end
            ST_B1: begin
                w_byte_en   = 1'b1;
                w_lane      = 2'd1;
                w_state_nxt = ST_B2;
            end
            ST_B2: begin
                w_byte_en   = 1'b1;
                w_lane      = 2'd0;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Byte address wraps naturally at the address width
    assign w_offset    = 2'd2 - w_lane;
    assign w_lane_sel  = {w_lane, 3'b000};
    assign w_byte_addr = r_addr + {{(ADDRESS_WIDTH-2){1'b0}}, w_offset};
    assign w_wr_byte   = r_wdata[w_lane_sel +: 8];
    assign w_rd_byte   = r_mem[w_byte_addr];

    // Byte captured into the response lane: store data echoes, load data from the array
    always_comb begin
        w_byte = 8'h00;
        if (r_write) begin
            w_byte = w_wr_byte;
        end else begin
            w_byte = w_rd_byte;
        end
    end

    // Request latch, response lane capture and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= {ADDRESS_WIDTH{1'b0}};
            r_write     <= 1'b0;
            r_wdata     <= {DATA_WIDTH{1'b0}};
            r_rdata     <= {DATA_WIDTH{1'b0}};
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && req_valid) begin
                r_addr  <= req_addr;
                r_write <= req_write;
                r_wdata <= req_wdata;
            end
            if (w_byte_en) begin
                r_rdata[w_lane_sel +: 8] <= w_byte;
            end
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Byte array: no reset, so a store cut short by reset keeps the bytes already written
    always_ff @(posedge clk) begin
        if (w_byte_en && r_write) begin
            r_mem[w_byte_addr] <= w_wr_byte;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sic_mem_responder.sv
// Directed bench for sic_mem_responder: stores, loads, wrap, latency,
// back-pressure, input changes after acceptance and reset in mid-store.
module tb_sic_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [14:0] req_addr;
    logic [23:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [23:0] rsp_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    sic_mem_responder #(
        .ADDRESS_WIDTH(15),
        .DATA_WIDTH   (24)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction with rsp_ready held high; request inputs are
    // scrambled right after acceptance and must have no effect.
    task automatic txn(input logic wr, input logic [14:0] addr, input logic [23:0] wd,
                       output logic [23:0] rd);
        int   n;
        logic rdy_bad;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_rdy", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = ~addr;
        req_wdata = ~wd;
        n = 1;
        rdy_bad = req_ready;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
            rdy_bad = rdy_bad | req_ready;
        end
        check("latency", n, 32'd4);
        check("rdy_lo", {31'd0, rdy_bad}, 32'd0);
        rd = rsp_rdata;
        @(negedge clk);
        check("vld_pulse", {31'd0, rsp_valid}, 32'd0);
        check("rdy_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] rd;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 15'd0;
        req_wdata = 24'd0;
        rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_rdata", {8'd0, rsp_rdata}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic store/load and unaligned word view
        txn(1'b1, 15'h0010, 24'h123456, rd);
        check("st_echo", {8'd0, rd}, 32'h00123456);
        txn(1'b0, 15'h0010, 24'h000000, rd);
        check("ld_0010", {8'd0, rd}, 32'h00123456);
        txn(1'b0, 15'h0012, 24'h000000, rd);
        check("ld_0012_b0", {24'd0, rd[23:16]}, 32'h56);

        // Address wrap at the top of the space
        txn(1'b1, 15'h7FFE, 24'hAABBCC, rd);
        check("st_wrap_echo", {8'd0, rd}, 32'h00AABBCC);
        txn(1'b0, 15'h0000, 24'h000000, rd);
        check("ld_0000_b0", {24'd0, rd[23:16]}, 32'hCC);
        txn(1'b0, 15'h7FFE, 24'h000000, rd);
        check("ld_7ffe", {8'd0, rd}, 32'h00AABBCC);
        txn(1'b0, 15'h7FFF, 24'h000000, rd);
        check("ld_7fff_hi", {16'd0, rd[23:8]}, 32'hBBCC);

        // Store with request inputs scrambled after acceptance
        txn(1'b1, 15'h0020, 24'h0A0B0C, rd);
        txn(1'b0, 15'h0020, 24'h000000, rd);
        check("ld_0020", {8'd0, rd}, 32'h000A0B0C);

        // Back-pressure: response held for 10 cycles while inputs toggle
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 15'h0010;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_start", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            req_valid = i[0];
            req_write = 1'b1;
            req_addr  = 15'h0010;
            req_wdata = 24'($urandom);
            @(negedge clk);
            check("hold_vld",  {31'd0, rsp_valid}, 32'd1);
            check("hold_data", {8'd0, rsp_rdata}, 32'h00123456);
            check("hold_rdy",  {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_release", {31'd0, rsp_valid}, 32'd0);
        txn(1'b0, 15'h0010, 24'h000000, rd);
        check("ld_after_hold", {8'd0, rd}, 32'h00123456);

        // Reset in the middle of a store keeps only the byte already written
        txn(1'b1, 15'h0100, 24'h000000, rd);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 15'h0100;
        req_wdata = 24'hFFFFFF;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
        check("mid_rst_rdata", {8'd0, rsp_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 15'h0100, 24'h000000, rd);
        check("ld_0100", {8'd0, rd}, 32'h00FF0000);

        // Overlapping store then load
        txn(1'b1, 15'h0021, 24'h112233, rd);
        txn(1'b0, 15'h0020, 24'h000000, rd);
        check("ld_overlap", {8'd0, rd}, 32'h000A1122);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
